// File: rtl/imu_message_reader393.sv
// Message-channel reader for the IMU logger: captures a timestamp per event, then streams a
// 32-halfword record (4 timestamp halfwords + 28 message halfwords) on a valid/ready port.
module imu_message_reader393 #(
   parameter logic [3:0]  CHANNEL     = 4'd3,
   parameter logic [15:0] RDY_TIMEOUT = 16'd65535
) (
   input  logic        xclk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        msg_ts_i,
   input  logic        msg_rdy_i,
   output logic        msg_rd_stb_o,
   input  logic [15:0] msg_rdata_i,
   output logic        ts_req_o,
   input  logic        ts_valid_i,
   input  logic [31:0] ts_sec_i,
   input  logic [19:0] ts_usec_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] out_data_o,
   output logic        out_first_o,
   output logic        out_last_o,
   output logic [7:0]  drop_cnt_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {StIdle, StTsWait, StRdyWait, StEmitTs, StEmitData} state_e;

   state_e      state_q, state_d;
   logic [4:0]  wcnt_q, wcnt_d;
   logic [15:0] tmo_q, tmo_d;
   logic [31:0] sec_q, sec_d;
   logic [19:0] usec_q, usec_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_data_q, out_data_d;
   logic        out_first_q, out_first_d;
   logic        out_last_q, out_last_d;
   logic [7:0]  drop_q, drop_d;

   logic        have_word, load, stb, ev_busy, ev_tmo;
   logic [15:0] word;
   logic [8:0]  drop_sum;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      tmo_d       = tmo_q;
      sec_d       = sec_q;
      usec_d      = usec_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      stb         = 1'b0;
      ev_tmo      = 1'b0;

      case (wcnt_q)
         5'd0:    word = usec_q[15:0];
         5'd1:    word = {CHANNEL, 8'h00, usec_q[19:16]};
         5'd2:    word = sec_q[15:0];
         5'd3:    word = sec_q[31:16];
         default: word = msg_rdata_i;
      endcase

      // hw0 is loaded straight out of RDY_WAIT so it appears two cycles after ts_valid
      have_word = (state_q == StRdyWait && msg_rdy_i) || state_q == StEmitTs ||
                  state_q == StEmitData;
      load      = en_i && have_word && (!out_valid_q || out_ready_i);
      ev_busy   = en_i && msg_ts_i && state_q != StIdle;

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = word;
         out_first_d = wcnt_q == 5'd0;
         out_last_d  = wcnt_q == 5'd31;
         wcnt_d      = wcnt_q + 5'd1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (msg_ts_i) state_d = StTsWait;
         end
         StTsWait: begin
            if (ts_valid_i) begin
               sec_d   = ts_sec_i;
               usec_d  = ts_usec_i;
               tmo_d   = 16'd0;
               state_d = StRdyWait;
            end
         end
         StRdyWait: begin
            if (msg_rdy_i) begin
               if (load) state_d = StEmitTs;
            end else begin
               tmo_d = tmo_q + 16'd1;
               if (tmo_d == RDY_TIMEOUT) begin
                  ev_tmo  = 1'b1;
                  wcnt_d  = 5'd0;
                  state_d = StIdle;
               end
            end
         end
         StEmitTs: begin
            if (load && wcnt_q == 5'd3) state_d = StEmitData;
         end
         StEmitData: begin
            stb = load;
            if (load && wcnt_q == 5'd31) begin
               wcnt_d  = 5'd0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      drop_sum = {1'b0, drop_q} + {8'd0, ev_busy} + {8'd0, ev_tmo};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

      if (!en_i) begin
         state_d     = StIdle;
         wcnt_d      = 5'd0;
         tmo_d       = 16'd0;
         out_valid_d = 1'b0;
         out_data_d  = 16'h0000;
         out_first_d = 1'b0;
         out_last_d  = 1'b0;
         drop_d      = drop_q;
      end
   end

   always_ff @(posedge xclk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         wcnt_q      <= 5'd0;
         tmo_q       <= 16'd0;
         sec_q       <= 32'd0;
         usec_q      <= 20'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 16'h0000;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         drop_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         tmo_q       <= tmo_d;
         sec_q       <= sec_d;
         usec_q      <= usec_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
         drop_q      <= drop_d;
      end
   end

   assign msg_rd_stb_o = stb;
   assign ts_req_o     = state_q == StTsWait;
   assign busy_o       = state_q != StIdle;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_first_o  = out_first_q;
   assign out_last_o   = out_last_q;
   assign drop_cnt_o   = drop_q;

endmodule

// File: doc/imu_message_reader393.md
Name: imu_message_reader393

Overview:
Downstream consumer of the odometer/external message channel in the IMU logger. On each debounced timestamp pulse it requests and latches a logger timestamp. It then waits for message-ready and drains the 28 halfwords of the message via rd_stb. The timestamp and message are emitted as one 32-halfword (64-byte) record on a valid/ready stream into the logger record multiplexer.

Parameters:
CHANNEL, 4'd3, logger channel number placed in record halfword 1 bits [15:12]
RDY_TIMEOUT, 16'd65535, xclk cycles to wait for msg_rdy after timestamp capture before abandoning the event

Ports:
xclk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-high
en  input  1  channel enable; low acts as soft reset of FSM and output stage, counters kept
msg_ts  input  1  one-cycle timestamp-request pulse from message source
msg_rdy  input  1  message-ready level from message source
msg_rd_stb  output  1  read strobe to message source; advances its halfword pointer
msg_rdata  input  16  current message halfword, combinational from source pointer
ts_req  output  1  timestamp request to logger timestamp unit
ts_valid  input  1  one-cycle pulse, timestamp valid
ts_sec  input  32  seconds
ts_usec  input  20  microseconds
out_valid  output  1  record halfword valid
out_ready  input  1  downstream accepts halfword
out_data  output  16  record halfword
out_first  output  1  marks halfword 0 of a record
out_last  output  1  marks halfword 31 of a record
drop_cnt  output  8  saturating count of dropped or abandoned events
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=1): FSM=IDLE; ts_req, msg_rd_stb, out_valid, out_first, out_last, busy all 0; out_data=0; drop_cnt=0; word counter=0. The en=0 condition does the same except drop_cnt is held.
- FSM states: IDLE, TS_WAIT, RDY_WAIT, EMIT_TS, EMIT_DATA.
- IDLE: on msg_ts go to TS_WAIT; ts_req is registered high from the next cycle.
- TS_WAIT: hold ts_req=1 until ts_valid. On ts_valid latch ts_sec/ts_usec, drop ts_req the next cycle, go to RDY_WAIT, clear the timeout counter.
- RDY_WAIT: if msg_rdy=1 go to EMIT_TS. Otherwise the timeout counter increments each cycle. When it reaches RDY_TIMEOUT: go to IDLE, emit no record, increment drop_cnt.
- Output stage: a single registered halfword. A "load" occurs when (!out_valid || out_ready) and the FSM has a word to present. A load sets out_valid=1 with out_data/out_first/out_last. If nothing is loaded and out_ready=1, out_valid clears.
- EMIT_TS: loads halfwords 0..3, one per load:
  - hw0 = ts_usec[15:0], out_first=1
  - hw1 = {CHANNEL, 8'h00, ts_usec[19:16]}
  - hw2 = ts_sec[15:0]
  - hw3 = ts_sec[31:16]
  - After hw3 go to EMIT_DATA.
- EMIT_DATA: each load takes out_data=msg_rdata and asserts msg_rd_stb for exactly that cycle. The source pointer advances next cycle, so back-to-back loads are legal at full rate. Exactly 28 loads are made (record halfwords 4..31). Halfword 31 has out_last=1. After it is loaded, FSM returns to IDLE.
- msg_rd_stb is never asserted outside EMIT_DATA loads. Total strobes per record = 28.
- Back-pressure: with out_ready=0 and out_valid=1, out_data, out_first, out_last are held and no msg_rd_stb is issued.
- msg_ts while busy=1: event ignored, drop_cnt increments. The current record still completes with 32 halfwords; content after the source's pointer reset is not guaranteed.
- msg_ts in the same cycle the FSM returns to IDLE: counted as a drop, not accepted.
- drop_cnt saturates at 8'hFF.
- msg_rdy falling before all 28 strobes: ignored, record completes.
- en falling mid-record: record truncated, out_valid cleared next cycle, no out_last issued. Downstream must discard the partial record on en low.
- Latency, out_ready held 1: msg_ts at cycle 0 -> ts_req at cycle 1. ts_valid at cycle N -> with msg_rdy already 1, hw0 valid at N+2. Last halfword at N+33.

Test Plan:
- Basic record: msg_ts; ts_valid 3 cycles later with sec=32'h12345678, usec=20'hABCDE; msg_rdy=1; msg_rdata = pointer index. Required: 32 halfwords 0xBCDE, 0x300A, 0x5678, 0x1234, 0x0000..0x001B; first/last flags on halfwords 0 and 31; 28 strobes.
- Back-pressure: same stimulus with out_ready toggling 1-0-0-1. Required: identical 32 halfwords, no duplicates or skips, strobes only on loads.
- Timeout: RDY_TIMEOUT=16, msg_rdy held 0 after ts_valid. Required: IDLE after 16 cycles, no out_valid, drop_cnt=1.
- Overrun: second msg_ts during EMIT_DATA. Required: drop_cnt increments, exactly 32 halfwords emitted, FSM then IDLE.
- Saturation: 300 drop events. Required: drop_cnt=8'hFF.
- Soft reset: en=0 at halfword 10. Required: out_valid=0 next cycle, busy=0, drop_cnt unchanged. A new msg_ts after en=1 produces a full record.
